// File: rtl/neuraedge_pkg.sv
// rtl/neuraedge_pkg.sv - shared types and sizing helpers for the NeuraEdge tile sequencer
// Purpose: tile FSM state encoding, flush-length and select-width helpers.
// Ports: none (package).
package neuraedge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } tile_state_e;

    // Cycles for the skewed wavefront to reach the far corner of the grid.
    function automatic int flush_cycles(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

    // Width of a select/counter able to index n values, never narrower than 1.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuraedge_sat_counter.sv
// rtl/neuraedge_sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts enabled cycles, sticks at all-ones, clear wins over enable.
// Ports: clk, rst_n (async low), clr, en in; count out (WIDTH).
module neuraedge_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/neuraedge_tile_ctrl.sv
// rtl/neuraedge_tile_ctrl.sv - per-tile sequencer for the NeuraEdge systolic PE array
// Purpose: clear accumulators, stream k_len edge beats, flush the wavefront, drain rows.
// Ports: clk, rst_n, start, k_len, abort, in_valid/in_ready, pe_enable, mac_clear,
//        accumulate_en, pe_data_valid, res_row_sel, res_valid/res_ready, busy, done,
//        busy_cycles.
module neuraedge_tile_ctrl
    import neuraedge_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int K_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    input  logic                         abort,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         pe_enable,
    output logic                         mac_clear,
    output logic                         accumulate_en,
    output logic                         pe_data_valid,
    output logic [sel_width(ROWS)-1:0]   res_row_sel,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         busy,
    output logic                         done,
    output logic [31:0]                  busy_cycles
);

    localparam int FLUSH_CYCLES = flush_cycles(ROWS, COLS);
    localparam int FLW          = sel_width(ROWS + COLS);
    localparam int RSW          = sel_width(ROWS);
    localparam logic [FLW-1:0] FLUSH_LAST = FLW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [RSW-1:0] ROW_LAST   = RSW'(ROWS - 1);
    // A 1x1 array has no skew to flush, so the last beat goes straight to draining.
    localparam tile_state_e AFTER_STREAM = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_DRAIN;

    tile_state_e        state_q, state_d;
    logic [K_WIDTH-1:0] k_cnt_q, k_cnt_d;
    logic [FLW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [RSW-1:0]     row_q, row_d;
    logic               busy_clr;

    always_comb begin
        state_d       = state_q;
        k_cnt_d       = k_cnt_q;
        flush_cnt_d   = '0;
        row_d         = '0;
        busy_clr      = 1'b0;
        in_ready      = 1'b0;
        pe_enable     = 1'b0;
        mac_clear     = 1'b0;
        accumulate_en = 1'b0;
        pe_data_valid = 1'b0;
        res_valid     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    busy_clr = 1'b1;
                    if (k_len != '0) begin
                        state_d = ST_CLEAR;
                        k_cnt_d = k_len;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CLEAR: begin
                mac_clear = 1'b1;
                pe_enable = 1'b1;
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                in_ready      = 1'b1;
                pe_enable     = 1'b1;
                accumulate_en = 1'b1;
                pe_data_valid = in_valid;
                if (in_valid) begin
                    k_cnt_d = k_cnt_q - K_WIDTH'(1);
                    if (k_cnt_q == K_WIDTH'(1)) begin
                        state_d = AFTER_STREAM;
                    end
                end
            end
            ST_FLUSH: begin
                pe_enable     = 1'b1;
                accumulate_en = 1'b1;
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLW'(1);
                end
            end
            ST_DRAIN: begin
                res_valid = 1'b1;
                row_d     = row_q;
                if (res_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = ST_DONE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RSW'(1);
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Cancel outranks every other transition; accumulators are left for the next CLEAR.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            flush_cnt_d = '0;
            row_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_cnt_q     <= '0;
            flush_cnt_q <= '0;
            row_q       <= '0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_q       <= row_d;
        end
    end

    assign res_row_sel = row_q;

    neuraedge_sat_counter #(
        .WIDTH (32)
    ) u_busy_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (busy_clr),
        .en    (busy),
        .count (busy_cycles)
    );

endmodule

// File: tb/tb_neuraedge_tile_ctrl.sv
// tb/tb_neuraedge_tile_ctrl.sv - scoreboard bench for neuraedge_tile_ctrl
`timescale 1ns/1ps
module tb_neuraedge_tile_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int KW   = 16;
    localparam int FL   = ROWS + COLS - 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          in_ready, pe_enable, mac_clear, accumulate_en, pe_data_valid;
    logic          res_valid, busy, done;
    logic [1:0]    res_row_sel;
    logic [31:0]   busy_cycles;

    int     tests = 0;
    int     fails = 0;
    longint cyc = 0;

    typedef struct {
        int     k;
        longint dcyc;
        int     total;
    } exp_t;

    exp_t exp_done[$];
    int   exp_rows[$];
    bit   vq[$];
    bit   rq[$];
    exp_t e_cur;
    int   beats = 0;
    int   clears = 0;
    bit   bc_pend = 1'b0;
    int   bc_exp = 0;

    neuraedge_tile_ctrl #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .K_WIDTH (KW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .k_len         (k_len),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pe_enable     (pe_enable),
        .mac_clear     (mac_clear),
        .accumulate_en (accumulate_en),
        .pe_data_valid (pe_data_valid),
        .res_row_sel   (res_row_sel),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .busy          (busy),
        .done          (done),
        .busy_cycles   (busy_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint all_outs();
        return longint'({in_ready, pe_enable, mac_clear, accumulate_en, pe_data_valid,
                         res_valid, busy, done, res_row_sel, busy_cycles});
    endfunction

    // Monitor: pops expectations whenever the DUT presents a row or a done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bc_pend) begin
                check("busy_cycles_at_end", busy_cycles, bc_exp);
                check("busy_after_done", busy, 0);
                bc_pend = 1'b0;
            end
            if (in_ready) check("pdv_follows_in_valid", pe_data_valid, in_valid);
            else if (pe_data_valid) check("pdv_outside_stream", pe_data_valid, 0);
            if (pe_data_valid) beats++;
            if (mac_clear) clears++;
            if (res_valid) check("drain_array_idle", {pe_enable, accumulate_en, in_ready}, 0);
            if (res_valid && res_ready) begin
                check("row_expected", exp_rows.size() > 0, 1);
                if (exp_rows.size() > 0) check("row_order", res_row_sel, exp_rows.pop_front());
            end
            if (done) begin
                check("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    e_cur = exp_done.pop_front();
                    check("done_cycle", cyc, e_cur.dcyc);
                    check("beats_per_tile", beats, e_cur.k);
                    check("mac_clears_per_tile", clears, (e_cur.k != 0) ? 1 : 0);
                    bc_pend = 1'b1;
                    bc_exp  = e_cur.total;
                end
            end
            if (!busy) begin
                beats  = 0;
                clears = 0;
            end
        end
    end

    task automatic gen(input int k);
        int c;
        bit b;
        vq.delete();
        rq.delete();
        c = 0;
        while (c < k) begin
            b = ($urandom_range(0, 2) != 0);
            vq.push_back(b);
            if (b) c++;
        end
        if (k != 0) begin
            c = 0;
            while (c < ROWS) begin
                b = ($urandom_range(0, 2) != 0);
                rq.push_back(b);
                if (b) c++;
            end
        end
    endtask

    // Issues one tile; in_valid/res_ready follow vq/rq on a timeline derived from the
    // tile's phase lengths, so expectations never depend on what the DUT reports.
    task automatic run_tile(input int k, input bit abort_at_start);
        int     s, d, d0, total, ones;
        longint p;
        s     = vq.size();
        d     = rq.size();
        d0    = 1 + s + FL;
        total = (k == 0) ? 1 : d0 + d + 1;
        start = 1'b1;
        k_len = KW'(k);
        abort = abort_at_start;
        in_valid  = 1'($urandom);
        res_ready = 1'($urandom);
        @(posedge clk); #1;
        p = cyc;
        exp_done.push_back('{k, p + total - 1, total});
        if (k != 0) for (int r = 0; r < ROWS; r++) exp_rows.push_back(r);
        abort = 1'b0;
        ones  = 0;
        for (int t = 0; t < total; t++) begin
            start     = 1'($urandom);
            k_len     = KW'($urandom);
            in_valid  = (t >= 1 && t <= s) ? vq[t-1] : 1'($urandom);
            res_ready = (t >= d0 && t < d0 + d) ? rq[t-d0] : 1'($urandom);
            #1;
            if (t >= 1 && t <= s) check("stream_beat", pe_data_valid, vq[t-1]);
            if (t >= d0 && t < d0 + d) begin
                check("drain_valid", res_valid, 1);
                check("drain_row_hold", res_row_sel, ones);
                if (rq[t-d0]) ones++;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // k_len=8, everything flowing: 20 busy cycles.
        vq.delete(); rq.delete();
        for (int i = 0; i < 8; i++) vq.push_back(1'b1);
        for (int i = 0; i < ROWS; i++) rq.push_back(1'b1);
        run_tile(8, 1'b0);
        check("tp1_busy_cycles", busy_cycles, 20);

        // k_len=3 with bubbles.
        vq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rq.delete();
        for (int i = 0; i < ROWS; i++) rq.push_back(1'b1);
        run_tile(3, 1'b0);

        // Writeback stalls five cycles on row 2.
        vq = '{1'b1, 1'b1};
        rq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        run_tile(2, 1'b0);

        // Zero-length tile.
        vq.delete(); rq.delete();
        run_tile(0, 1'b0);
        check("k0_busy_cycles", busy_cycles, 1);

        // Abort after two of eight beats.
        start = 1'b1; k_len = KW'(8);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        check("abort_idle", {busy, in_ready, pe_enable}, 0);
        check("abort_no_done", done, 0);
        check("abort_busy_cycles", busy_cycles, 4);
        vq = '{1'b1};
        rq.delete();
        for (int i = 0; i < ROWS; i++) rq.push_back(1'b1);
        run_tile(1, 1'b0);

        // Start while streaming is ignored, then reset lands in FLUSH.
        start = 1'b1; k_len = KW'(2);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; k_len = KW'(9);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("flush_after_k_beats", {in_ready, accumulate_en, pe_enable}, 3'b011);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 20; n++) begin
            int k;
            k = $urandom_range(0, 12);
            gen(k);
            run_tile(k, 1'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        check("done_queue_drained", exp_done.size(), 0);
        check("row_queue_drained", exp_rows.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuraedge_tile_ctrl.md
# neuraedge_tile_ctrl

Sequencer for one output tile of the NeuraEdge systolic PE array: clears the PE accumulators, streams K operand beats into the array edge under a valid/ready handshake, waits for the skewed wavefront to flush through the ROWS×COLS grid, then drains accumulated results one row at a time to the writeback path. It sits between the operand buffer and the array's broadcast control lines (pe_enable, mac_clear, accumulate_en) and edge data_valid.

## Interface
- ROWS, 4, PE array rows (≥1)
- COLS, 4, PE array columns (≥1)
- K_WIDTH, 16, width of the accumulation-length field
- Clock and reset: clk; rst_n, asynchronous, active-low.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  launch one tile; sampled only in IDLE
- k_len  in  K_WIDTH  accumulation beats for the tile; latched on accepted start
- abort  in  1  synchronous cancel of the tile in progress
- in_valid  in  1  operand buffer has an edge beat
- in_ready  out  1  controller accepts a beat this cycle
- pe_enable  out  1  array multiply enable
- mac_clear  out  1  array accumulator clear
- accumulate_en  out  1  array accumulate enable
- pe_data_valid  out  1  edge data_valid into the array
- res_row_sel  out  max(1,$clog2(ROWS))  row whose accum_out is presented
- res_valid  out  1  selected row result valid
- res_ready  in  1  writeback accepts the row
- busy  out  1  tile in progress
- done  out  1  one-cycle tile-complete pulse
- busy_cycles  out  32  cycles spent busy in the last/current tile, saturating

## Operation
- States: IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE (Moore, one state register).
- IDLE: start=1 with k_len≠0 → CLEAR, latch k_len into k_cnt, zero busy_cycles. start=1 with k_len=0 → DONE directly (no clear, no stream). start=0 → stay.
- CLEAR (1 cycle): mac_clear=1, pe_enable=1 → STREAM.
- STREAM: in_ready=1, pe_enable=1, accumulate_en=1; pe_data_valid = in_valid (combinational, only in STREAM). Each accepted beat decrements k_cnt; the beat taking k_cnt 1→0 moves to FLUSH (or DRAIN if FLUSH_CYCLES=0). in_valid=0 is a bubble: no decrement, pe_data_valid=0.
- FLUSH: FLUSH_CYCLES = ROWS+COLS-2 cycles; pe_enable=1, accumulate_en=1, pe_data_valid=0, in_ready=0 → DRAIN.
- DRAIN: pe_enable=0, accumulate_en=0 (accumulators hold); res_valid=1, res_row_sel starts at 0, increments on res_valid&&res_ready; handshake on row ROWS-1 → DONE. res_ready=0 stalls indefinitely.
- DONE (1 cycle): done=1 → IDLE.
- busy=1 in every state except IDLE. busy_cycles increments each busy cycle, saturates at 2^32-1, holds in IDLE until next accepted start.
- abort=1 in any non-IDLE state → IDLE next edge; done not pulsed; accumulators left stale (next tile clears them). abort has priority over every other transition. abort in IDLE ignored; start in any non-IDLE state ignored.
- Reset: state=IDLE, k_cnt=0, res_row_sel=0, busy_cycles=0; all outputs 0.

## Timing
- Accepted start at edge E0: CLEAR during cycle E0..E1, first possible beat accepted at E2.
- Continuous in_valid, res_ready=1: busy duration = 1 + k_len + (ROWS+COLS-2) + ROWS + 1 cycles.
- All outputs except pe_data_valid are decodes of registered state/counters; pe_data_valid has one combinational path from in_valid.
- k_cnt width K_WIDTH; flush counter width $clog2(ROWS+COLS) (min 1); no arithmetic wraps.

## Structure
- neuraedge_pkg: tile_state_e enum, function for FLUSH_CYCLES, shared row-select width function.
- One sub-module: neuraedge_sat_counter (32-bit saturating, clear/enable) for busy_cycles.

## Test plan
- ROWS=COLS=4, k_len=8, in_valid and res_ready held 1 → mac_clear one cycle, 8 pe_data_valid beats, 6 flush cycles, rows 0..3, done; busy_cycles=20.
- k_len=3, in_valid toggling 1,0,1,0,1 → exactly 3 beats accepted, FLUSH entered after third, no pe_data_valid during bubbles.
- k_len=0 start → done one cycle later, mac_clear never asserted, busy for exactly one cycle.
- DRAIN with res_ready low 5 cycles on row 2 → res_row_sel holds 2, res_valid stays 1, accumulate_en 0 throughout.
- abort mid-STREAM after 2 of 8 beats → IDLE next cycle, no done; following start k_len=1 runs cleanly with fresh mac_clear.
- rst_n asserted in FLUSH → all outputs 0 immediately; start while busy (STREAM) ignored, k_len not relatched.
